// File: rtl/seg7_scan_capture.sv
// Display readback: watches the multiplexed active-low anode/segment lines and
// recovers the BCD digit lit on each anode once it has been stable long enough.

module seg7_digit_lane (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       wr,
    input  logic [3:0] nib,
    output logic [3:0] digit,
    output logic       valid
);
    // clr outranks a write landing on the same edge
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            digit <= 4'hF;
            valid <= 1'b0;
        end else if (wr) begin
            digit <= nib;
            valid <= 1'b1;
        end
    end
endmodule

module seg7_scan_capture #(
    parameter int NUM_DIGITS = 8,
    parameter int STABLE_CYC = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              an,
    input  logic [6:0]              seg,
    input  logic                    clr,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    seg_err
);
    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [7:0] IN_MASK = 8'((1 << NUM_DIGITS) - 1);

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
    } samp_t;

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    // Decisions compare the sample taken on this edge against the registered
    // previous sample, so the STABLE_CYC-th identical sample is the capture edge.
    samp_t cur, prev_q;
    assign cur = {an, seg};

    always_ff @(posedge clk) begin
        if (rst) prev_q <= {8'hFF, 7'h7F};
        else     prev_q <= cur;
    end

    logic [7:0] low;
    logic [2:0] sel_idx;
    logic       sel_ok;
    logic       changed;

    assign low     = ~cur.an;
    assign changed = (cur != prev_q);

    always_comb begin
        sel_idx = 3'd0;
        for (int i = 0; i < 8; i++)
            if (low[i]) sel_idx = 3'(i);
        sel_ok = $onehot(low) && ((low & ~IN_MASK) == 8'h00);
    end

    logic [3:0] nib;
    logic       dec_err;

    always_comb begin
        nib     = 4'hE;
        dec_err = 1'b0;
        case (cur.seg)
            7'b1000000: nib = 4'd0;
            7'b1111001: nib = 4'd1;
            7'b0100100: nib = 4'd2;
            7'b0110000: nib = 4'd3;
            7'b0011001: nib = 4'd4;
            7'b0010010: nib = 4'd5;
            7'b0000010: nib = 4'd6;
            7'b1111000: nib = 4'd7;
            7'b0000000: nib = 4'd8;
            7'b0010000: nib = 4'd9;
            7'b1111111: nib = 4'hF;
            default:    dec_err = 1'b1;
        endcase
    end

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cap;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_ok) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_ONE;
                end
            end
            SETTLE, HOLD: begin
                if (changed) begin
                    state_d = sel_ok ? SETTLE : IDLE;
                    cnt_d   = sel_ok ? CNT_ONE : '0;
                end else if (state_q == SETTLE && cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (state_d == SETTLE && cnt_d == CNT_MAX) begin
            cap     = 1'b1;
            state_d = HOLD;
        end
    end

    logic [NUM_DIGITS-1:0] wr;
    logic [NUM_DIGITS-1:0] seen_q;
    logic                  frame_hit;

    always_comb begin
        wr = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            wr[i] = cap && (sel_idx == 3'(i));
    end

    assign frame_hit = cap && ((seen_q | wr) == {NUM_DIGITS{1'b1}});

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            seen_q     <= '0;
            frame_done <= 1'b0;
            seg_err    <= 1'b0;
        end else begin
            frame_done <= frame_hit;
            seen_q     <= frame_hit ? '0 : (seen_q | wr);
            if (cap && dec_err) seg_err <= 1'b1;
        end
    end

    logic [NUM_DIGITS-1:0][3:0] dig;
    assign digits = dig;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
        seg7_digit_lane u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .wr    (wr[g]),
            .nib   (nib),
            .digit (dig[g]),
            .valid (digit_valid[g])
        );
    end
endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: decode table plus hand-built
// sequences for timing, aborts, frames, clr and reset corner cases.

module tb_seg7_scan_capture;
    logic        clk = 1'b0;
    logic        rst, clr;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic [31:0] digits;
    logic [7:0]  digit_valid;
    logic        frame_done, seg_err;
    logic [15:0] digits4;
    logic [3:0]  valid4;
    logic        frame4, err4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seg7_scan_capture u_dut (
        .clk(clk), .rst(rst), .an(an), .seg(seg), .clr(clr),
        .digits(digits), .digit_valid(digit_valid),
        .frame_done(frame_done), .seg_err(seg_err)
    );

    seg7_scan_capture #(.NUM_DIGITS(4)) u_dut4 (
        .clk(clk), .rst(rst), .an(an), .seg(seg), .clr(clr),
        .digits(digits4), .digit_valid(valid4),
        .frame_done(frame4), .seg_err(err4)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    typedef struct {
        logic [6:0] seg;
        int         hold;
        logic [3:0] nib;
        logic       err;
    } vec_t;

    logic [6:0] pat [10];
    vec_t       tbl [13];
    int         frames, pulse_at;

    initial begin
        pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
        pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
        pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
        pat[9] = 7'b0010000;
        for (int k = 0; k < 10; k++) tbl[k] = '{pat[k], 5, 4'(k), 1'b0};
        tbl[10] = '{7'b1111111, 5, 4'hF, 1'b0};
        tbl[11] = '{7'b0101010, 5, 4'hE, 1'b1};
        tbl[12] = '{pat[3],     5, 4'h3, 1'b1};

        // reset state
        rst = 1'b1; clr = 1'b0; an = 8'hFF; seg = 7'h7F;
        tick(2);
        chk("rst digits", digits, 32'hFFFF_FFFF);
        chk("rst valid", 32'(digit_valid), 32'h0);
        chk("rst frame", 32'(frame_done), 32'h0);
        chk("rst err", 32'(seg_err), 32'h0);
        chk("rst digits4", 32'(digits4), 32'hFFFF);
        rst = 1'b0;
        tick(1);

        // capture lands on the 4th sampling edge, not before
        an = 8'hFE; seg = pat[2];
        tick(3);
        chk("t2 before capture", 32'(digit_valid), 32'h0);
        tick(1);
        chk("t2 digit0", 32'(digits[3:0]), 32'h2);
        chk("t2 valid", 32'(digit_valid), 32'h01);

        // segments toggling every 3 cycles never settle
        seg = pat[7]; tick(3);
        seg = pat[8]; tick(3);
        seg = pat[7]; tick(3);
        an = 8'hFF; tick(6);
        chk("t2 abort keeps digit", 32'(digits[3:0]), 32'h2);

        // decode table on anode 0
        an = 8'hFE;
        for (int k = 0; k < 13; k++) begin
            seg = tbl[k].seg;
            tick(tbl[k].hold);
            chk($sformatf("dec[%0d] nib", k), 32'(digits[3:0]), 32'(tbl[k].nib));
            chk($sformatf("dec[%0d] err", k), 32'(seg_err), 32'(tbl[k].err));
        end

        pulse_clr();
        chk("clr err", 32'(seg_err), 32'h0);
        chk("clr valid", 32'(digit_valid), 32'h0);
        chk("clr digits", digits, 32'hFFFF_FFFF);
        tick(5);
        chk("hold no recapture", 32'(digit_valid), 32'h0);

        // two full scans, one frame pulse each
        for (int s = 0; s < 2; s++) begin
            frames = 0; pulse_at = -1;
            for (int i = 0; i < 8; i++) begin
                an  = 8'(~(8'h01 << i));
                seg = pat[i + 1];
                for (int c = 0; c < 6; c++) begin
                    tick(1);
                    if (frame_done) begin
                        frames++;
                        pulse_at = i * 6 + c;
                    end
                end
            end
            chk($sformatf("scan%0d digits", s), digits, 32'h8765_4321);
            chk($sformatf("scan%0d valid", s), 32'(digit_valid), 32'hFF);
            chk($sformatf("scan%0d frames", s), 32'(frames), 32'd1);
            chk($sformatf("scan%0d pulse cycle", s), 32'(pulse_at), 32'd45);
        end
        chk("scan digits4", 32'(digits4), 32'h4321);

        // undecodable pattern, then valid digit on same anode
        an = 8'hFB; seg = 7'b0101010;
        tick(5);
        chk("t4 digit2 E", 32'(digits[11:8]), 32'hE);
        chk("t4 err set", 32'(seg_err), 32'h1);
        seg = pat[5];
        tick(5);
        chk("t4 digit2 5", 32'(digits[11:8]), 32'h5);
        chk("t4 err sticky", 32'(seg_err), 32'h1);
        pulse_clr();
        chk("t4 clr err", 32'(seg_err), 32'h0);

        // invalid selects leave everything alone
        an = 8'hFC; seg = pat[1]; tick(10);
        chk("t5 two-low digits", digits, 32'hFFFF_FFFF);
        chk("t5 two-low valid", 32'(digit_valid), 32'h0);
        an = 8'hFF; tick(10);
        chk("t5 none digits", digits, 32'hFFFF_FFFF);
        chk("t5 none flags", {29'd0, frame_done, seg_err, |digit_valid}, 32'h0);
        an = 8'hEF; tick(10);
        chk("t5 oor digits4", 32'(digits4), 32'hFFFF);
        chk("t5 oor valid4", 32'(valid4), 32'h0);
        chk("t5 anode4 on 8-digit", 32'(digits[19:16]), 32'h1);

        // clr on the capture edge wins
        pulse_clr();
        an = 8'hFE; seg = pat[3];
        tick(3);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("t6 clr-cap valid", 32'(digit_valid), 32'h0);
        chk("t6 clr-cap digits", digits, 32'hFFFF_FFFF);
        tick(4);
        chk("t6 clr-cap no recapture", 32'(digit_valid), 32'h0);

        // reset mid-settle restarts the stability window
        an = 8'hFD; seg = pat[6];
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t6 rst digits", digits, 32'hFFFF_FFFF);
        chk("t6 rst valid", 32'(digit_valid), 32'h0);
        tick(3);
        chk("t6 no early capture", 32'(digit_valid), 32'h0);
        tick(1);
        chk("t6 fresh capture valid", 32'(digit_valid), 32'h02);
        chk("t6 fresh capture digit", 32'(digits[7:4]), 32'h6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
